// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Multi-cycle MIPS ALU. Single-cycle logic/arith/shift/compare ops
//            with registered one-cycle latency; iterative signed/unsigned
//            multiply and (optionally) divide writing a HI/LO pair, driven by
//            a start/busy/done handshake.
// Options  : ALU_DIV_EN -- when defined, DIV/DIVU are built; otherwise their
//            codes behave as reserved (1-cycle done with op_err).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             op_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_SLL   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
`endif

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {upper, lower}: product or {remainder, quotient}
  logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               op_err_q, op_err_d;
`ifdef ALU_DIV_EN
  logic               is_div_q, is_div_d;
`endif

  logic               op_simple, op_mul, op_div, op_signed;
  logic [WIDTH-1:0]   simple_res, mag_a, mag_b;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] step_next, mul_prod;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign shamt = input2[SHW-1:0];

  // Opcode decode and the single-cycle operation results
  always_comb begin
    op_simple  = 1'b0;
    op_mul     = 1'b0;
    op_div     = 1'b0;
    op_signed  = (AluCtrl == OP_MULT);
    simple_res = '0;
    case (AluCtrl)
      OP_AND:   begin op_simple = 1'b1; simple_res = input1 & input2;    end
      OP_OR:    begin op_simple = 1'b1; simple_res = input1 | input2;    end
      OP_ADD:   begin op_simple = 1'b1; simple_res = input1 + input2;    end
      OP_XOR:   begin op_simple = 1'b1; simple_res = input1 ^ input2;    end
      OP_NOR:   begin op_simple = 1'b1; simple_res = ~(input1 | input2); end
      OP_SUB:   begin op_simple = 1'b1; simple_res = input1 - input2;    end
      OP_SLTU:  begin op_simple = 1'b1; simple_res = {{(WIDTH-1){1'b0}}, (input1 < input2)}; end
      OP_SLT:   begin op_simple = 1'b1; simple_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))}; end
      OP_SLL:   begin op_simple = 1'b1; simple_res = input1 << shamt;    end
      OP_SRL:   begin op_simple = 1'b1; simple_res = input1 >> shamt;    end
      OP_SRA:   begin op_simple = 1'b1; simple_res = $signed(input1) >>> shamt; end
      OP_MULT, OP_MULTU: op_mul = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV:   begin op_div = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  op_div = 1'b1;
`endif
      default:  ;
    endcase
    mag_a = (op_signed && input1[WIDTH-1]) ? -input1 : input1;
    mag_b = (op_signed && input2[WIDTH-1]) ? -input2 : input2;
  end

  // One iteration step plus the final sign-corrected HI/LO values
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    step_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_prod  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    fix_hi    = mul_prod[2*WIDTH-1:WIDTH];
    fix_lo    = mul_prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
    if (is_div_q) begin
      // Restoring step: trial-subtract the divisor from the shifted remainder
      logic [WIDTH:0] trial;
      trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
      if (!trial[WIDTH])
        step_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        step_next = {acc_q[2*WIDTH-2:0], 1'b0};
      // Remainder follows the dividend sign; a zero divisor leaves the
      // dividend in the remainder and an all-ones quotient, uncorrected.
      fix_hi = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      if (opb_q == '0)
        fix_lo = '1;
      else
        fix_lo = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
`endif
  end

  // Next-state logic: IDLE -> ITER (WIDTH steps) -> FIX -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start && (op_mul || op_div)) begin
        state_d = S_ITER;
        cnt_d   = CNT_LAST;
      end
      S_ITER: begin
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - SHW'(1);
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output register updates for each state
  always_comb begin
    acc_d    = acc_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    op_err_d = 1'b0;
`ifdef ALU_DIV_EN
    is_div_d = is_div_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        if (op_simple) begin
          result_d = simple_res;
          zero_d   = (simple_res == '0);
          done_d   = 1'b1;
        end else if (op_mul || op_div) begin
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          opb_d    = mag_b;
          sign_a_d = op_signed & input1[WIDTH-1];
          sign_b_d = op_signed & input2[WIDTH-1];
`ifdef ALU_DIV_EN
          is_div_d = op_div;
`endif
        end else begin
          result_d = '0;
          zero_d   = 1'b1;
          done_d   = 1'b1;
          op_err_d = 1'b1;
        end
      end
      S_ITER: acc_d = step_next;
      S_FIX: begin
        hi_d     = fix_hi;
        lo_d     = fix_lo;
        result_d = fix_lo;
        zero_d   = (fix_lo == '0);
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      op_err_q <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      op_err_q <= op_err_d;
`ifdef ALU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign done   = done_q;
  assign op_err = op_err_q;
  assign busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the MIPS CPU datapath. It keeps the single-cycle logic/arithmetic/shift/compare operations with a registered one-cycle latency. It adds iterative signed/unsigned multiply and divide that write a HI/LO pair. The control unit drives it with a start/busy/done handshake and stalls the PC while `busy` is high.

## Interface
- `WIDTH`, 32: operand, result, HI and LO width; must be ≥ 8 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width; only `input2[SHW-1:0]` is used.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  operation request; sampled only when `busy`=0.
- `AluCtrl`  in  4  operation code.
- `input1`, `input2`  in  WIDTH  operands A and B.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  registered; 1 when `result`==0.
- `hi`, `lo`  out  WIDTH  registered multiply/divide outputs.
- `busy`  out  1  multiply/divide in progress.
- `done`  out  1  one-cycle pulse; outputs valid for the completed operation.
- `op_err`  out  1  one-cycle pulse with `done` for a reserved or disabled code.

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0110 SUB.
  - 0111 SLTU, unsigned A<B; 1000 SLT, signed A<B.
  - 1100 SLL; 0101 SRL; 1101 SRA; shift amount is B[SHW-1:0].
  - 1001 MULT; 1010 MULTU; 1011 DIV; 1110 DIVU.
  - 1111 reserved.
- All add/sub arithmetic is modulo 2^WIDTH. No overflow flag.
- Simple ops:
  - Update `result` and `zero` only.
  - `hi` and `lo` hold their values.
- Multiply:
  - {`hi`,`lo`} = full 2·WIDTH product. Signed MULT is done on magnitudes, then negated when the operand signs differ.
  - `result` = low half of the product.
- Divide:
  - `lo` = quotient, truncated toward zero; `hi` = remainder, with the sign of the dividend.
  - `result` = quotient.
  - Divisor 0: `lo` = all ones, `hi` = dividend, `op_err` = 0.
  - DIV of −2^(WIDTH−1) by −1: `lo` = −2^(WIDTH−1), `hi` = 0.
- Reserved code: `result`=0, `zero`=1, `hi`/`lo` hold, `op_err` pulses.
- FSM:
  - IDLE: on `start` with a simple or reserved code, compute, register the outputs, pulse `done`, and stay in IDLE. On `start` with a mul/div code, latch the operand magnitudes and sign bits, and go to ITER.
  - ITER: one shift-add (multiply) or restoring-subtract (divide) step per cycle. The iteration counter runs WIDTH−1 down to 0; at 0, go to FIX.
  - FIX: apply sign correction, write `hi`/`lo`/`result`/`zero`, pulse `done`, go to IDLE.
- `start` while `busy`=1 is ignored; the operation is not queued.
- Operands and code are captured at acceptance. Input changes during `busy` have no effect.

## Timing
- Reset values: `result`=0, `zero`=1, `hi`=0, `lo`=0, `busy`=0, `done`=0, `op_err`=0, state IDLE, counter 0.
- Reset mid-operation aborts immediately; the next cycle is IDLE with reset values. No `done` is issued for the aborted operation.
- Simple ops: `start` at cycle 0 → outputs and `done` at cycle 1.
- Mul/div: `start` at cycle 0 → `busy`=1 in cycles 1..WIDTH+1 → `done` and valid outputs at cycle WIDTH+2 with `busy`=0.
- Throughput:
  - A new `start` can be accepted in the same cycle `done` is high, because the state is IDLE.
  - Back-to-back simple ops produce one result per cycle.
- Outputs hold their values between operations.

## Configuration
- `ALU_DIV_EN` defined: DIV/DIVU are implemented as above.
- `ALU_DIV_EN` undefined:
  - The divide datapath is not synthesised.
  - Codes 1011 and 1110 are treated as reserved: 1-cycle `done`, `op_err`=1, `result`=0, `hi`/`lo` hold.
  - MULT/MULTU are unaffected.

## Test plan
All cases use WIDTH=32.
- Reset, then idle: `result`=0, `zero`=1, `hi`=`lo`=0, `busy`=0.
- SLT with A=0xFFFFFFFF, B=1 → `result`=1. SLTU with the same operands → `result`=0, `zero`=1. SRA with A=0x80000000, B=4 → 0xF8000000. Each `done` arrives at cycle 1.
- MULTU with A=B=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` at cycle 34. MULT with the same operands → `hi`=0, `lo`=1.
- DIV with A=−7 (0xFFFFFFF9), B=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU with A=100, B=0 → `lo`=0xFFFFFFFF, `hi`=0x64.
- Start MULTU, pulse `start` again at cycle 5 with new operands → the second request is ignored and the first result arrives at cycle 34. Assert `rst` at cycle 10 of a second MULTU → no `done`, outputs return to reset values.
- Build without `ALU_DIV_EN`: DIV at cycle 0 → `done` and `op_err` at cycle 1, `result`=0, `hi`/`lo` unchanged.
